// File: rtl/virtual_button_decoder_pkg.sv
// Shared definitions for the virtual-interface button path: decoder FSM
// encoding, default frame header and button bit positions.
package virtual_iface_pkg;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] GOT_HDR = 3'd1;
  localparam logic [2:0] GOT_B0  = 3'd2;
  localparam logic [2:0] GOT_B1  = 3'd3;
  localparam logic [2:0] GOT_B2  = 3'd4;

  localparam logic [7:0] HEADER_DEFAULT = 8'hB0;

  localparam int BTN_RIGHT = 0;
  localparam int BTN_LEFT  = 1;

  typedef logic [23:0] btn_vec_t;

  // XOR of the header and the three payload bytes; a frame is valid when CHK equals this.
  function automatic logic [7:0] frame_checksum(input logic [7:0] hdr, input btn_vec_t payload);
    return hdr ^ payload[7:0] ^ payload[15:8] ^ payload[23:16];
  endfunction

endpackage

// File: rtl/frame_timeout_counter.sv
// Idle-gap counter for the frame decoder; saturates at TIMEOUT_CYCLES and
// flags expiry while it sits there.
module frame_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 100000,
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LIMIT)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (cnt == LIMIT);

endmodule

// File: rtl/virtual_button_decoder.sv
// Assembles 5-byte button frames from the virtual interface byte stream,
// checks the XOR checksum and updates the 24-bit button register atomically.
module virtual_button_decoder
  import virtual_iface_pkg::*;
#(
  parameter logic [7:0] HEADER         = HEADER_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [23:0] buttons,
  output logic        frame_ok,
  output logic        frame_err
);

  logic [2:0] state;
  btn_vec_t   shadow;
  logic       expired;
  logic       in_frame;

  assign in_frame = (state != IDLE);

  // A byte always restarts the gap count; the counter is parked at zero outside a frame.
  frame_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (rx_valid || !in_frame || expired),
    .enable (in_frame && !rx_valid),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shadow    <= '0;
      buttons   <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      if (rx_valid) begin
        // A byte arriving on the expiry cycle is processed; the timeout is ignored.
        case (state)
          IDLE: begin
            if (rx_data == HEADER) state <= GOT_HDR;
          end
          GOT_HDR: begin
            shadow[7:0] <= rx_data;
            state       <= GOT_B0;
          end
          GOT_B0: begin
            shadow[15:8] <= rx_data;
            state        <= GOT_B1;
          end
          GOT_B1: begin
            shadow[23:16] <= rx_data;
            state         <= GOT_B2;
          end
          GOT_B2: begin
            if (rx_data == frame_checksum(HEADER, shadow)) begin
              buttons  <= shadow;
              frame_ok <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (expired) begin
        state     <= IDLE;
        shadow    <= '0;
        frame_err <= 1'b1;
      end
    end
  end

endmodule
